// File: rtl/popcount_arbiter_pkg.sv
// rtl/popcount_arbiter_pkg.sv - shared widths, types and round-robin helper for popcount_arbiter
//
// Purpose : default sizing for the popcount arbiter slice, the requester-ID and
//           occupancy types, and the modulo-NUM_REQ pointer increment.
// Ports   : none (package).
`ifndef CFG_VEC_WIDTH
`define CFG_VEC_WIDTH 8
`endif
`ifndef CFG_VEC_POPCOUNT_WIDTH
`define CFG_VEC_POPCOUNT_WIDTH 4
`endif

package popcount_arb_pkg;

  localparam int DEF_NUM_REQ         = 4;
  localparam int DEF_MAX_OUTSTANDING = 4;
  localparam int DEF_VEC_WIDTH       = `CFG_VEC_WIDTH;
  localparam int DEF_POPCNT_WIDTH    = `CFG_VEC_POPCOUNT_WIDTH;

  localparam int PKG_ID_WIDTH  = (DEF_NUM_REQ > 1) ? $clog2(DEF_NUM_REQ) : 1;
  localparam int PKG_OCC_WIDTH = $clog2(DEF_MAX_OUTSTANDING + 1);

  typedef logic [PKG_ID_WIDTH-1:0]  req_id_t;
  typedef logic [PKG_OCC_WIDTH-1:0] occ_t;

  // Wraps at num_req, not at the next power of two, so non-power-of-two
  // requester counts never point at a requester that does not exist.
  function automatic int unsigned next_rr(input int unsigned ptr, input int unsigned num_req);
    return (ptr + 1 >= num_req) ? 32'd0 : ptr + 1;
  endfunction

endpackage

// File: rtl/popcount_tag_fifo.sv
// rtl/popcount_tag_fifo.sv - in-order requester-ID FIFO for popcount_arbiter
//
// Purpose : remembers which requester issued each outstanding popcount so the
//           result can be routed back in issue order.
// Ports   : clk, rst_n (sync, active-low)
//           push, push_data  - enqueue one ID (ignored when full)
//           pop              - dequeue head (ignored when empty)
//           full, empty      - derived from registered occupancy
//           count            - registered occupancy
//           head             - ID at the head of the queue
module popcount_tag_fifo #(
  parameter int WIDTH     = 2,
  parameter int DEPTH     = 4,
  parameter int CNT_WIDTH = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 push,
  input  logic [WIDTH-1:0]     push_data,
  input  logic                 pop,
  output logic                 full,
  output logic                 empty,
  output logic [CNT_WIDTH-1:0] count,
  output logic [WIDTH-1:0]     head
);

  localparam int PTR_WIDTH = $clog2(DEPTH);

  logic [WIDTH-1:0]     mem [DEPTH];
  logic [PTR_WIDTH-1:0] wr_ptr;
  logic [PTR_WIDTH-1:0] rd_ptr;
  logic                 do_push;
  logic                 do_pop;

  // Full/empty come from the registered count only, so a pop in the same
  // cycle never makes room for a push.
  assign full    = (count == CNT_WIDTH'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_WIDTH'(1);
        2'b01:   count <= count - CNT_WIDTH'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/popcount_arbiter.sv
// rtl/popcount_arbiter.sv - shares one Popcount datapath among NUM_REQ valid/ready requesters
//
// Purpose : round-robin request arbitration with a grant lock on the input
//           side, in-order result routing through a tag FIFO on the output side.
//           Zero added latency in either direction.
// Ports   : clk, rst_n (sync, active-low)
//           req_valid/req_ready/req_vec  - per-requester vector streams
//           rsp_valid/rsp_ready          - per-requester result handshake
//           rsp_popcount                 - shared result bus
//           pc_in_valid/pc_in_ready/pc_vec              - to/from Popcount input
//           pc_out_valid/pc_next_ready/pc_popcount      - to/from Popcount output
//           outstanding   - tag FIFO occupancy
//           err_underflow - sticky: a result arrived with no outstanding tag
module popcount_arbiter
  import popcount_arb_pkg::*;
#(
  parameter int    NUM_REQ         = DEF_NUM_REQ,
  parameter int    VEC_WIDTH       = DEF_VEC_WIDTH,
  parameter int    POPCNT_WIDTH    = DEF_POPCNT_WIDTH,
  parameter int    MAX_OUTSTANDING = DEF_MAX_OUTSTANDING,
  localparam int   ID_WIDTH        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int   OCC_WIDTH       = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*VEC_WIDTH-1:0] req_vec,
  output logic [NUM_REQ-1:0]           rsp_valid,
  input  logic [NUM_REQ-1:0]           rsp_ready,
  output logic [POPCNT_WIDTH-1:0]      rsp_popcount,
  output logic                         pc_in_valid,
  input  logic                         pc_in_ready,
  output logic [VEC_WIDTH-1:0]         pc_vec,
  input  logic                         pc_out_valid,
  output logic                         pc_next_ready,
  input  logic [POPCNT_WIDTH-1:0]      pc_popcount,
  output logic [OCC_WIDTH-1:0]         outstanding,
  output logic                         err_underflow
);

  logic [ID_WIDTH-1:0] rr_ptr;
  logic                lock;
  logic [ID_WIDTH-1:0] locked_id;
  logic [ID_WIDTH-1:0] grant;
  logic [ID_WIDTH-1:0] head;
  logic                fifo_full;
  logic                fifo_empty;
  logic                can_issue;
  logic                accept;
  logic                pop;
  logic                head_ready;

  // Grant: first valid requester at or above rr_ptr, else first valid below
  // it. Scanning downward leaves the lowest matching index in each half.
  logic                found_hi;
  logic                found_lo;
  logic [ID_WIDTH-1:0] grant_hi;
  logic [ID_WIDTH-1:0] grant_lo;

  always_comb begin
    found_hi = 1'b0;
    found_lo = 1'b0;
    grant_hi = '0;
    grant_lo = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        if (ID_WIDTH'(i) >= rr_ptr) begin
          found_hi = 1'b1;
          grant_hi = ID_WIDTH'(i);
        end else begin
          found_lo = 1'b1;
          grant_lo = ID_WIDTH'(i);
        end
      end
    end
    if (lock)          grant = locked_id;
    else if (found_hi) grant = grant_hi;
    else if (found_lo) grant = grant_lo;
    else               grant = rr_ptr;
  end

  // Every handshake output is forced low while reset is asserted, before the
  // registered state has had a clock edge to clear.
  assign can_issue   = !fifo_full;
  assign pc_in_valid = rst_n && can_issue && (lock || (|req_valid));
  assign accept      = pc_in_valid && pc_in_ready;

  always_comb begin
    pc_vec    = '0;
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant == ID_WIDTH'(i)) begin
        req_ready[i] = rst_n && can_issue && pc_in_ready;
        if (pc_in_valid) pc_vec = req_vec[i*VEC_WIDTH +: VEC_WIDTH];
      end
    end
  end

  // Results are delivered strictly in issue order: a stalled head blocks
  // everything behind it.
  always_comb begin
    rsp_valid  = '0;
    head_ready = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (head == ID_WIDTH'(i)) begin
        rsp_valid[i] = rst_n && pc_out_valid && !fifo_empty;
        head_ready   = rsp_ready[i];
      end
    end
  end

  assign rsp_popcount  = pc_popcount;
  assign pc_next_ready = rst_n && !fifo_empty && head_ready;
  assign pop           = pc_out_valid && pc_next_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr        <= '0;
      lock          <= 1'b0;
      locked_id     <= '0;
      err_underflow <= 1'b0;
    end else begin
      if (accept) begin
        lock   <= 1'b0;
        rr_ptr <= ID_WIDTH'(next_rr(32'(grant), NUM_REQ));
      end else if (pc_in_valid) begin
        // Offered but not taken: freeze the grant so the vector on pc_vec
        // cannot change under Popcount. A full FIFO leaves the lock untouched.
        lock      <= 1'b1;
        locked_id <= grant;
      end
      if (pc_out_valid && fifo_empty) begin
        err_underflow <= 1'b1;
      end
    end
  end

  popcount_tag_fifo #(
    .WIDTH     (ID_WIDTH),
    .DEPTH     (MAX_OUTSTANDING),
    .CNT_WIDTH (OCC_WIDTH)
  ) u_tag_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (accept),
    .push_data (grant),
    .pop       (pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (outstanding),
    .head      (head)
  );

endmodule

// File: tb/tb_popcount_arbiter.sv
// tb/tb_popcount_arbiter.sv - self-checking bench for popcount_arbiter
module tb_popcount_arbiter;

  localparam int N  = 4;
  localparam int M  = 4;
  localparam int VW = popcount_arb_pkg::DEF_VEC_WIDTH;
  localparam int PW = popcount_arb_pkg::DEF_POPCNT_WIDTH;
  localparam int OW = $clog2(M + 1);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*VW-1:0] req_vec;
  logic [N-1:0]    rsp_valid;
  logic [N-1:0]    rsp_ready;
  logic [PW-1:0]   rsp_popcount;
  logic            pc_in_valid;
  logic            pc_in_ready;
  logic [VW-1:0]   pc_vec;
  logic            pc_out_valid;
  logic            pc_next_ready;
  logic [PW-1:0]   pc_popcount;
  logic [OW-1:0]   outstanding;
  logic            err_underflow;

  popcount_arbiter #(
    .NUM_REQ(N), .VEC_WIDTH(VW), .POPCNT_WIDTH(PW), .MAX_OUTSTANDING(M)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_vec(req_vec),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_popcount(rsp_popcount),
    .pc_in_valid(pc_in_valid), .pc_in_ready(pc_in_ready), .pc_vec(pc_vec),
    .pc_out_valid(pc_out_valid), .pc_next_ready(pc_next_ready), .pc_popcount(pc_popcount),
    .outstanding(outstanding), .err_underflow(err_underflow)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Producers: one vector queue per requester.
  logic [VW-1:0] send_mem [N][16];
  int            send_hd  [N];
  int            send_tl  [N];

  // Popcount stand-in: in-order queue of accepted vectors.
  logic          out_en    = 1'b0;
  logic          force_out = 1'b0;
  logic [VW-1:0] pc_q [$];
  int            q_count   = 0;
  logic [PW-1:0] q_front_pc = '0;
  assign pc_out_valid = (out_en && q_count > 0) || force_out;
  assign pc_popcount  = q_front_pc;

  // Reference: outstanding (requester, expected popcount) in issue order,
  // plus arbitration state derived from the round-robin/lock rules.
  int sb_id [$];
  int sb_pc [$];
  int acc_log [$];
  int rsp_id_log [$];
  int rsp_pc_log [$];
  int ref_ptr  = 0;
  bit ref_lock = 0;
  int ref_id   = 0;
  bit ref_err  = 0;

  bit            p_rst = 0, p_acc = 0, p_lock_set = 0, p_out_hs = 0, p_und = 0;
  int            p_g = 0;
  logic [VW-1:0] p_vec = '0;

  task automatic drive_reqs();
    for (int i = 0; i < N; i++) begin
      req_valid[i] = (send_hd[i] != send_tl[i]);
      req_vec[i*VW +: VW] = req_valid[i] ? send_mem[i][send_hd[i] % 16] : '0;
    end
  endtask

  task automatic enq(input int i, input logic [VW-1:0] v);
    send_mem[i][send_tl[i] % 16] = v;
    send_tl[i]++;
    drive_reqs();
  endtask

  task automatic clear_producers();
    for (int i = 0; i < N; i++) begin
      send_hd[i] = 0;
      send_tl[i] = 0;
    end
    drive_reqs();
  endtask

  function automatic int exp_grant();
    if (ref_lock) return ref_id;
    for (int k = 0; k < N; k++) begin
      if (req_valid[(ref_ptr + k) % N]) return (ref_ptr + k) % N;
    end
    return 0;
  endfunction

  function automatic bit busy();
    for (int i = 0; i < N; i++) if (send_hd[i] != send_tl[i]) return 1'b1;
    return (sb_id.size() != 0);
  endfunction

  // Continuous checker, sampled mid-cycle.
  always @(negedge clk) begin
    int            g;
    bit            piv_exp;
    logic [N-1:0]  exp_rv;
    logic          exp_nr;
    logic [N-1:0]  exp_rr;
    p_rst = !rst_n; p_acc = 0; p_lock_set = 0; p_out_hs = 0; p_und = 0;
    if (rst_n) begin
      g       = exp_grant();
      piv_exp = (sb_id.size() < M) && (ref_lock || (req_valid != '0));
      n_checks++;
      if (outstanding !== OW'(sb_id.size())) begin
        n_fail++; $display("FAIL outstanding: got %0d expected %0d", outstanding, sb_id.size());
      end
      n_checks++;
      if (err_underflow !== ref_err) begin
        n_fail++; $display("FAIL err_underflow: got %0b expected %0b", err_underflow, ref_err);
      end
      n_checks++;
      if (pc_in_valid !== piv_exp) begin
        n_fail++; $display("FAIL pc_in_valid: got %0b expected %0b", pc_in_valid, piv_exp);
      end
      if (piv_exp) begin
        exp_rr = pc_in_ready ? (N'(1) << g) : N'(0);
        n_checks++;
        if (pc_vec !== req_vec[g*VW +: VW]) begin
          n_fail++; $display("FAIL pc_vec: got %0h expected %0h (grant %0d)", pc_vec, req_vec[g*VW +: VW], g);
        end
        n_checks++;
        if (req_ready !== exp_rr) begin
          n_fail++; $display("FAIL req_ready: got %b expected %b", req_ready, exp_rr);
        end
        p_g = g; p_vec = req_vec[g*VW +: VW];
        p_acc = pc_in_ready; p_lock_set = !pc_in_ready;
      end else begin
        n_checks++;
        if (pc_vec !== '0) begin
          n_fail++; $display("FAIL pc_vec_idle: got %0h expected 0", pc_vec);
        end
        if (sb_id.size() >= M) begin
          n_checks++;
          if (req_ready !== '0) begin
            n_fail++; $display("FAIL req_ready_full: got %b expected 0", req_ready);
          end
        end
      end
      if (sb_id.size() != 0) begin
        exp_rv = pc_out_valid ? (N'(1) << sb_id[0]) : N'(0);
        exp_nr = rsp_ready[sb_id[0]];
      end else begin
        exp_rv = '0;
        exp_nr = 1'b0;
      end
      n_checks++;
      if (rsp_valid !== exp_rv) begin
        n_fail++; $display("FAIL rsp_valid: got %b expected %b", rsp_valid, exp_rv);
      end
      n_checks++;
      if (pc_next_ready !== exp_nr) begin
        n_fail++; $display("FAIL pc_next_ready: got %0b expected %0b", pc_next_ready, exp_nr);
      end
      if (pc_out_valid && sb_id.size() != 0 && exp_nr) begin
        p_out_hs = 1;
        n_checks++;
        if (rsp_popcount !== PW'(sb_pc[0])) begin
          n_fail++; $display("FAIL rsp_popcount: got %0d expected %0d", rsp_popcount, sb_pc[0]);
        end
        rsp_id_log.push_back(sb_id[0]);
        rsp_pc_log.push_back(int'(rsp_popcount));
      end
      if (pc_out_valid && sb_id.size() == 0) p_und = 1;
    end
  end

  // Reference/model update just after each active edge.
  always begin
    @(posedge clk);
    #1;
    if (p_rst) begin
      sb_id.delete(); sb_pc.delete(); pc_q.delete();
      ref_ptr = 0; ref_lock = 0; ref_err = 0;
    end else begin
      if (p_out_hs) begin
        void'(sb_id.pop_front()); void'(sb_pc.pop_front()); void'(pc_q.pop_front());
      end
      if (p_acc) begin
        sb_id.push_back(p_g);
        sb_pc.push_back($countones(p_vec));
        pc_q.push_back(p_vec);
        acc_log.push_back(p_g);
        send_hd[p_g]++;
        ref_lock = 0;
        ref_ptr  = (p_g + 1) % N;
      end else if (p_lock_set) begin
        ref_lock = 1;
        ref_id   = p_g;
      end
      if (p_und) ref_err = 1;
    end
    q_count    = pc_q.size();
    q_front_pc = (pc_q.size() != 0) ? PW'($countones(pc_q[0])) : '0;
    drive_reqs();
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_producers();
    tick(); tick();
    rst_n = 1'b1;
    acc_log.delete(); rsp_id_log.delete(); rsp_pc_log.delete();
  endtask

  task automatic wait_idle(input int budget, input string name);
    int c = 0;
    while (busy() && c < budget) begin tick(); c++; end
    n_checks++;
    if (busy()) begin
      n_fail++; $display("FAIL %s_timeout: still busy after %0d cycles, expected idle", name, budget);
    end
  endtask

  task automatic check_log(input string name, input int got[$], input int exp[$]);
    n_checks++;
    if (got.size() != exp.size()) begin
      n_fail++; $display("FAIL %s_len: got %0d expected %0d", name, got.size(), exp.size());
    end else begin
      for (int i = 0; i < exp.size(); i++) begin
        n_checks++;
        if (got[i] != exp[i]) begin
          n_fail++; $display("FAIL %s[%0d]: got %0d expected %0d", name, i, got[i], exp[i]);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; pc_in_ready = 1'b1; out_en = 1'b1; force_out = 1'b1; rsp_ready = '1;
    clear_producers();
    enq(1, 8'h5A);
    tick(); tick();
    n_checks++;
    if (req_ready !== '0) begin n_fail++; $display("FAIL rst_req_ready: got %b expected 0", req_ready); end
    n_checks++;
    if (rsp_valid !== '0) begin n_fail++; $display("FAIL rst_rsp_valid: got %b expected 0", rsp_valid); end
    n_checks++;
    if (pc_in_valid !== 1'b0) begin n_fail++; $display("FAIL rst_pc_in_valid: got %b expected 0", pc_in_valid); end
    n_checks++;
    if (pc_next_ready !== 1'b0) begin n_fail++; $display("FAIL rst_pc_next_ready: got %b expected 0", pc_next_ready); end
    n_checks++;
    if (outstanding !== '0) begin n_fail++; $display("FAIL rst_outstanding: got %0d expected 0", outstanding); end
    n_checks++;
    if (err_underflow !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b expected 0", err_underflow); end
    force_out = 1'b0;
    do_reset();
  endtask

  task automatic test_single();
    do_reset();
    pc_in_ready = 1'b1; out_en = 1'b1; rsp_ready = '1;
    enq(0, 8'h01); enq(0, 8'h03); enq(0, 8'h07);
    wait_idle(50, "single");
    check_log("single_acc", acc_log, '{0, 0, 0});
    check_log("single_rsp_id", rsp_id_log, '{0, 0, 0});
    check_log("single_rsp_pc", rsp_pc_log, '{1, 2, 3});
  endtask

  task automatic test_round_robin();
    do_reset();
    pc_in_ready = 1'b1; out_en = 1'b1; rsp_ready = '1;
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < N; i++) enq(i, VW'($urandom));
    wait_idle(100, "rr");
    check_log("rr_acc", acc_log, '{0, 1, 2, 3, 0, 1, 2, 3});
    check_log("rr_rsp_id", rsp_id_log, '{0, 1, 2, 3, 0, 1, 2, 3});
  endtask

  task automatic test_full();
    do_reset();
    pc_in_ready = 1'b1; out_en = 1'b1; rsp_ready = '0;
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < N; i++) enq(i, VW'($urandom));
    repeat (10) tick();
    n_checks++;
    if (acc_log.size() != M) begin n_fail++; $display("FAIL full_accepts: got %0d expected %0d", acc_log.size(), M); end
    n_checks++;
    if (outstanding !== OW'(M)) begin n_fail++; $display("FAIL full_outstanding: got %0d expected %0d", outstanding, M); end
    n_checks++;
    if (req_ready !== '0) begin n_fail++; $display("FAIL full_req_ready: got %b expected 0", req_ready); end
    rsp_ready = '1;
    wait_idle(100, "full");
    check_log("full_acc", acc_log, '{0, 1, 2, 3, 0, 1, 2, 3});
    check_log("full_rsp_id", rsp_id_log, '{0, 1, 2, 3, 0, 1, 2, 3});
  endtask

  task automatic test_lock();
    do_reset();
    pc_in_ready = 1'b0; out_en = 1'b1; rsp_ready = '1;
    enq(2, 8'hF0); tick();
    enq(1, 8'h01); tick();
    enq(3, 8'h33); tick(); tick();
    n_checks++;
    if (pc_vec !== 8'hF0) begin n_fail++; $display("FAIL lock_pc_vec: got %0h expected f0", pc_vec); end
    n_checks++;
    if (req_ready[1] !== 1'b0) begin n_fail++; $display("FAIL lock_req_ready1: got %b expected 0", req_ready[1]); end
    pc_in_ready = 1'b1;
    wait_idle(50, "lock");
    check_log("lock_acc", acc_log, '{2, 3, 1});
  endtask

  task automatic test_hol();
    do_reset();
    pc_in_ready = 1'b1; out_en = 1'b1; rsp_ready = '0;
    enq(1, 8'hFF); tick(); tick();
    enq(0, 8'h01); tick(); tick();
    rsp_ready = 4'b0001;
    tick(); tick();
    n_checks++;
    if (pc_next_ready !== 1'b0) begin n_fail++; $display("FAIL hol_next_ready: got %b expected 0", pc_next_ready); end
    n_checks++;
    if (rsp_valid !== 4'b0010) begin n_fail++; $display("FAIL hol_rsp_valid: got %b expected 0010", rsp_valid); end
    n_checks++;
    if (outstanding !== OW'(2)) begin n_fail++; $display("FAIL hol_outstanding: got %0d expected 2", outstanding); end
    rsp_ready = '1;
    wait_idle(50, "hol");
    check_log("hol_rsp_id", rsp_id_log, '{1, 0});
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      pc_in_ready = 1'($urandom_range(0, 3) != 0);
      out_en      = 1'($urandom_range(0, 3) != 0);
      rsp_ready   = N'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        int r = int'($urandom_range(0, N - 1));
        if (send_tl[r] - send_hd[r] < 8) enq(r, VW'($urandom));
      end
      tick();
    end
    pc_in_ready = 1'b1; out_en = 1'b1; rsp_ready = '1;
    wait_idle(200, "random");
    n_checks++;
    if (rsp_id_log.size() != acc_log.size()) begin
      n_fail++; $display("FAIL random_rsp_count: got %0d expected %0d", rsp_id_log.size(), acc_log.size());
    end
    check_log("random_order", rsp_id_log, acc_log);
  endtask

  task automatic test_reset_underflow();
    do_reset();
    pc_in_ready = 1'b1; out_en = 1'b1; rsp_ready = '0;
    enq(0, 8'h11); enq(1, 8'h22); enq(2, 8'h44);
    repeat (6) tick();
    n_checks++;
    if (outstanding !== OW'(3)) begin n_fail++; $display("FAIL ru_outstanding_pre: got %0d expected 3", outstanding); end
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    n_checks++;
    if (outstanding !== '0) begin n_fail++; $display("FAIL ru_outstanding_post: got %0d expected 0", outstanding); end
    n_checks++;
    if (rsp_valid !== '0) begin n_fail++; $display("FAIL ru_rsp_valid: got %b expected 0", rsp_valid); end
    acc_log.delete();
    rsp_ready = '1;
    enq(2, 8'h0F); enq(3, 8'hF0);
    wait_idle(50, "ru");
    check_log("ru_acc_after_reset", acc_log, '{2, 3});
    force_out = 1'b1; tick();
    n_checks++;
    if (err_underflow !== 1'b1) begin n_fail++; $display("FAIL ru_err_set: got %b expected 1", err_underflow); end
    n_checks++;
    if (pc_next_ready !== 1'b0) begin n_fail++; $display("FAIL ru_next_ready: got %b expected 0", pc_next_ready); end
    force_out = 1'b0;
    repeat (3) tick();
    n_checks++;
    if (err_underflow !== 1'b1) begin n_fail++; $display("FAIL ru_err_sticky: got %b expected 1", err_underflow); end
    rst_n = 1'b0; tick();
    rst_n = 1'b1; tick();
    n_checks++;
    if (err_underflow !== 1'b0) begin n_fail++; $display("FAIL ru_err_cleared: got %b expected 0", err_underflow); end
  endtask

  initial begin
    rst_n = 1'b0; pc_in_ready = 1'b0; rsp_ready = '0;
    req_valid = '0; req_vec = '0;
    clear_producers();
    test_reset();
    test_single();
    test_round_robin();
    test_full();
    test_lock();
    test_hol();
    test_random();
    test_reset_underflow();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/popcount_arbiter.md
Name: popcount_arbiter

Overview:
Shares one Popcount datapath instance among NUM_REQ independent valid/ready requesters.
- Input side: round-robin arbitration with a grant lock, so a presented vector stays stable until it is accepted.
- Output side: an in-order tag FIFO of requester IDs routes each popcount result back to the requester that issued it.
- Placement: between the vector producers and Popcount. Popcount's in_valid/this_ready/vec/out_valid/next_ready/popcount connect to the pc_* ports.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- VEC_WIDTH, `CFG_VEC_WIDTH, input vector width.
- POPCNT_WIDTH, `CFG_VEC_POPCOUNT_WIDTH, result width.
- MAX_OUTSTANDING, 4, tag FIFO depth; power of 2, ≥2.
- ID_WIDTH (localparam), max(1, $clog2(NUM_REQ)), requester ID width.
- OCC_WIDTH (localparam), $clog2(MAX_OUTSTANDING+1), occupancy width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- req_valid  in  NUM_REQ  per-requester vector valid.
- req_ready  out  NUM_REQ  per-requester accept.
- req_vec  in  NUM_REQ*VEC_WIDTH  flattened vectors; requester i at [i*VEC_WIDTH +: VEC_WIDTH].
- rsp_valid  out  NUM_REQ  per-requester result valid (one-hot or zero).
- rsp_ready  in  NUM_REQ  per-requester result ready.
- rsp_popcount  out  POPCNT_WIDTH  shared result bus.
- pc_in_valid  out  1  to Popcount in_valid.
- pc_in_ready  in  1  from Popcount this_ready.
- pc_vec  out  VEC_WIDTH  to Popcount vec.
- pc_out_valid  in  1  from Popcount out_valid.
- pc_next_ready  out  1  to Popcount next_ready.
- pc_popcount  in  POPCNT_WIDTH  from Popcount popcount.
- outstanding  out  OCC_WIDTH  tag FIFO occupancy.
- err_underflow  out  1  sticky: result arrived with empty tag FIFO.

Behaviour:
- Reset (rst_n=0 at posedge):
  - rr_ptr=0, lock=0, tag FIFO empty, outstanding=0, err_underflow=0.
  - All req_ready/rsp_valid/pc_in_valid/pc_next_ready=0 while in reset.
  - Popcount shares rst_n, so a mid-operation reset discards all in-flight work. No result is delivered after reset.
- Grant selection (combinational): first i with req_valid[i]=1, searching from rr_ptr upward modulo NUM_REQ.
- Grant lock:
  - If pc_in_valid=1 and pc_in_ready=0 at a posedge, set lock=1 and latch locked_id=grant.
  - While lock=1, grant=locked_id regardless of other requests; the locked requester holds req_valid per protocol.
  - lock clears on accept.
- Issue (combinational):
  - can_issue = !fifo_full.
  - pc_in_valid = can_issue && (lock || |req_valid).
  - pc_vec = req_vec[grant]; 0 when pc_in_valid=0.
  - req_ready[grant] = can_issue && pc_in_ready; all others 0.
- Accept (pc_in_valid && pc_in_ready at posedge): push grant ID; rr_ptr <= (grant+1) mod NUM_REQ. rr_ptr changes only on accept.
- Full:
  - fifo_full is evaluated on registered occupancy; a same-cycle pop does not free the slot.
  - When outstanding==MAX_OUTSTANDING, pc_in_valid=0. If lock=1, lock is retained.
- Response routing (combinational):
  - head = FIFO head ID.
  - rsp_valid[head] = pc_out_valid && !fifo_empty.
  - rsp_popcount = pc_popcount.
  - pc_next_ready = !fifo_empty && rsp_ready[head].
  - Pop on pc_out_valid && pc_next_ready.
  - Head-of-line blocking is intentional: results stay in order.
- Push and pop in the same cycle: both occur and outstanding is unchanged.
- Empty-FIFO result: pc_out_valid=1 with fifo_empty → pc_next_ready=0, err_underflow<=1, held until reset.
- Latency: zero added cycles in both directions (pure combinational pass-through plus bookkeeping).
- Width rules: rr_ptr wraps at NUM_REQ, not 2^ID_WIDTH. FIFO pointers wrap at MAX_OUTSTANDING.

Decomposition:
- Package popcount_arb_pkg:
  - req_id_t (logic [ID_WIDTH-1:0]).
  - occ_t.
  - Function next_rr(ptr) implementing modulo-NUM_REQ increment.
- Widths come from config.vh macros.
- One sub-module: popcount_tag_fifo, a synchronous FIFO (WIDTH=ID_WIDTH, DEPTH=MAX_OUTSTANDING, synchronous active-low reset) with push/pop/full/empty/count/head outputs.

Test Plan:
- Single requester: requester 0 sends 0x1, 0x3, 0x7; rsp_ready all 1 → rsp_valid[0] only, rsp_popcount 1, 2, 3 in order; outstanding returns to 0.
- Round-robin fairness: all four requesters valid after reset, two transactions each → accept order 0,1,2,3,0,1,2,3; each response on the matching rsp_valid index.
- Full FIFO: MAX_OUTSTANDING=4 and rsp_ready all 0 → exactly 4 accepts, outstanding=4, req_ready all 0. Raise rsp_ready → drain of 4 in order, then issue resumes.
- Grant lock: pc_in_ready held 0, requester 2 valid, then requester 1 valid next cycle → pc_vec stays requester 2's vector and req_ready[1]=0. Release pc_in_ready → requester 2 accepted first, then requester 3 checked before requester 1 (rr_ptr=3).
- Head-of-line blocking: head ID=1, rsp_ready[1]=0, rsp_ready[0]=1 → pc_next_ready=0, no pop, rsp_valid=0b0010 held.
- Reset and underflow: reset with 3 outstanding → next cycle outstanding=0, rr_ptr=0, all rsp_valid 0. Force pc_out_valid=1 with empty FIFO → err_underflow=1, stays 1 until rst_n=0.
